// File: rtl/qdec_if.sv
// qdec_if: encoder pins and decoded outputs of the quadrature front end.
// The index channel (zidx/zpulse) exists only when QDEC_INDEX_EN is defined.
// master = encoder/consumer side, slave = the qdec block itself.
interface qdec_if;
    logic       a;
    logic       b;
    logic       step;
    logic       dir;
    logic       err;
    logic [1:0] ab;
`ifdef QDEC_INDEX_EN
    logic       zidx;
    logic       zpulse;
`endif

    modport master (
        output a,
        output b,
`ifdef QDEC_INDEX_EN
        output zidx,
        input  zpulse,
`endif
        input  step,
        input  dir,
        input  err,
        input  ab
    );

    modport slave (
        input  a,
        input  b,
`ifdef QDEC_INDEX_EN
        input  zidx,
        output zpulse,
`endif
        output step,
        output dir,
        output err,
        output ab
    );
endinterface

// File: rtl/qdec.sv
// qdec: quadrature A/B encoder front end. Synchronises and de-glitches the
// asynchronous pins, decodes Gray-code transitions and emits registered
// one-cycle step pulses with a held direction level, plus an err pulse when
// both channels change in the same cycle.
// Optional feature macro: QDEC_INDEX_EN adds the zidx input and zpulse output.
module qdec #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 3,
    parameter int RES         = 4
) (
    input  logic  clk,
    input  logic  sclr,
    qdec_if.slave bus
);

`ifdef QDEC_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif
    localparam int            SETTLE_LEN  = SYNC_STAGES + FILTER + 1;
    localparam int            SW          = $clog2(SETTLE_LEN + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN - 1);

    typedef enum logic {SETTLE, RUN} state_t;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("qdec: SYNC_STAGES must be at least 2");
        end
        if (RES != 1 && RES != 2 && RES != 4) begin : g_bad_res
            $error("qdec: RES must be 1, 2 or 4");
        end
    endgenerate

    // Channel order: bit 0 = B, bit 1 = A, bit 2 = index (when present).
    logic [NCH-1:0]         raw;
    logic [SYNC_STAGES-1:0] sync_q [NCH];
    logic [NCH-1:0]         synced;
    logic [NCH-1:0]         filt;

`ifdef QDEC_INDEX_EN
    assign raw = {bus.zidx, bus.a, bus.b};
`else
    assign raw = {bus.a, bus.b};
`endif

    // Synchroniser shift chain per channel; oldest bit is the synced level.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (sclr) sync_q[i] <= '0;
            else      sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        end
    end

    // Pick the last synchroniser stage of every channel.
    always_comb begin
        synced = '0;
        for (int i = 0; i < NCH; i++) synced[i] = sync_q[i][SYNC_STAGES-1];
    end

    generate
        if (FILTER == 0) begin : g_nofilt
            assign filt = synced;
        end else begin : g_filt
            localparam int            CW    = $clog2(FILTER + 1);
            localparam logic [CW-1:0] FLAST = CW'(FILTER - 1);
            logic [CW-1:0]  cnt_q [NCH];
            logic [NCH-1:0] filt_q;

            // Accept a new level only after it differs for FILTER consecutive cycles.
            always_ff @(posedge clk) begin
                for (int i = 0; i < NCH; i++) begin
                    if (sclr) begin
                        cnt_q[i]  <= '0;
                        filt_q[i] <= 1'b0;
                    end else if (synced[i] == filt_q[i]) begin
                        cnt_q[i]  <= '0;
                    end else if (cnt_q[i] == FLAST) begin
                        cnt_q[i]  <= '0;
                        filt_q[i] <= ~filt_q[i];
                    end else begin
                        cnt_q[i]  <= cnt_q[i] + 1'b1;
                    end
                end
            end
            assign filt = filt_q;
        end
    endgenerate

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [1:0]    cur, prev_q, fwd_next;
    logic          step_q, step_d;
    logic          err_q, err_d;
    logic          dir_q, dir_d;

    assign cur = filt[1:0];

    // State register and settle counter; sclr forces SETTLE from scratch.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q  <= SETTLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Settle sequencing and Gray-code decode of prev -> cur.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        step_d   = 1'b0;
        err_d    = 1'b0;
        dir_d    = dir_q;
        fwd_next = 2'b00;
        case (prev_q)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            default: fwd_next = 2'b00;
        endcase
        if (state_q == SETTLE) begin
            settle_d = settle_q + 1'b1;
            if (settle_q == SETTLE_LAST) state_d = RUN;
        end else if (cur != prev_q) begin
            if (cur[1] != prev_q[1] && cur[0] != prev_q[0]) begin
                err_d = 1'b1;
            end else begin
                dir_d = (cur == fwd_next);
                if (RES == 4)      step_d = 1'b1;
                else if (RES == 2) step_d = (cur[1] != prev_q[1]);
                else if (RES == 1) step_d = (prev_q == 2'b00 && cur == 2'b10) ||
                                            (prev_q == 2'b10 && cur == 2'b00);
            end
        end
    end

    // Registered outputs; prev follows the filtered state in both states.
    always_ff @(posedge clk) begin
        if (sclr) begin
            prev_q <= 2'b00;
            step_q <= 1'b0;
            err_q  <= 1'b0;
            dir_q  <= 1'b1;
        end else begin
            prev_q <= cur;
            step_q <= step_d;
            err_q  <= err_d;
            dir_q  <= dir_d;
        end
    end

    assign bus.step = step_q;
    assign bus.err  = err_q;
    assign bus.dir  = dir_q;
    assign bus.ab   = cur;

`ifdef QDEC_INDEX_EN
    logic zprev_q, zpulse_q;

    // Index pulse on a filtered rising edge, suppressed while settling.
    always_ff @(posedge clk) begin
        if (sclr) begin
            zprev_q  <= 1'b0;
            zpulse_q <= 1'b0;
        end else begin
            zprev_q  <= filt[2];
            zpulse_q <= (state_q == RUN) && filt[2] && !zprev_q;
        end
    end

    assign bus.zpulse = zpulse_q;
`endif

endmodule

// File: tb/tb_qdec.sv
// tb_qdec: directed bench for qdec. Two instances share the encoder pins:
// dut4 decodes X4 and dut1 decodes X1, both with SYNC_STAGES=2, FILTER=3.
module tb_qdec;
    logic clk = 1'b0;
    logic sclr;
    logic pin_a;
    logic pin_b;

    int tests_run    = 0;
    int tests_failed = 0;

    int steps4 = 0, fwd4 = 0, rev4 = 0, errs4 = 0;
    int steps1 = 0, fwd1 = 0, rev1 = 0, errs1 = 0;

    logic [1:0] fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] rev_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    qdec_if bus4 ();
    qdec_if bus1 ();

    assign bus4.a = pin_a;
    assign bus4.b = pin_b;
    assign bus1.a = pin_a;
    assign bus1.b = pin_b;
`ifdef QDEC_INDEX_EN
    assign bus4.zidx = 1'b0;
    assign bus1.zidx = 1'b0;
`endif

    qdec #(.SYNC_STAGES(2), .FILTER(3), .RES(4)) dut4 (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus4)
    );

    qdec #(.SYNC_STAGES(2), .FILTER(3), .RES(1)) dut1 (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus1)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, split by direction.
    always @(negedge clk) begin
        if (bus4.step) begin
            steps4++;
            if (bus4.dir) fwd4++;
            else          rev4++;
        end
        if (bus1.step) begin
            steps1++;
            if (bus1.dir) fwd1++;
            else          rev1++;
        end
        if (bus4.err) errs4++;
        if (bus1.err) errs1++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive pins {a,b} and hold for the given number of clocks (called at posedge+1).
    task automatic applyStimulus(input logic [1:0] v, input int cycles);
        {pin_a, pin_b} = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [1:0] v);
        {pin_a, pin_b} = v;
        sclr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sclr = 1'b0;
    endtask

    initial begin
        int s4, f4, r4, e4, s1, f1, r1, e1;

        // Test 1: reset with pins at 11, then settle quietly
        sclr  = 1'b1;
        pin_a = 1'b1;
        pin_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_step", bus4.step, 0);
        checkOutput("rst_err",  bus4.err,  0);
        checkOutput("rst_dir",  bus4.dir,  1);
        checkOutput("rst_ab",   bus4.ab,   0);
        @(posedge clk);
        #1;
        sclr = 1'b0;
        s4 = steps4; e4 = errs4; s1 = steps1; e1 = errs1;
        applyStimulus(2'b11, 20);
        checkOutput("settle_steps4", steps4 - s4, 0);
        checkOutput("settle_errs4",  errs4 - e4,  0);
        checkOutput("settle_steps1", steps1 - s1, 0);
        checkOutput("settle_errs1",  errs1 - e1,  0);
        checkOutput("settle_ab",     bus4.ab,     2'b11);
        checkOutput("settle_dir",    bus4.dir,    1);

        // Test 2: one forward cycle at 10 clocks per state, exact latency of 6
        doReset(2'b00);
        applyStimulus(2'b00, 20);
        s4 = steps4; f4 = fwd4; s1 = steps1;
        for (int i = 0; i < 4; i++) begin
            {pin_a, pin_b} = fwd_seq[i];
            repeat (5) @(posedge clk);
            @(negedge clk);
            checkOutput("lat_before", bus4.step, 0);
            @(negedge clk);
            checkOutput("lat_step", bus4.step, 1);
            checkOutput("lat_dir",  bus4.dir,  1);
            @(negedge clk);
            checkOutput("lat_width", bus4.step, 0);
            repeat (3) @(posedge clk);
            #1;
        end
        checkOutput("x4_fwd_steps", steps4 - s4, 4);
        checkOutput("x4_fwd_dir1",  fwd4 - f4,   4);
        checkOutput("x1_one_cycle", steps1 - s1, 1);

        // Test 3: 8 forward then 8 reverse cycles, 5 clocks per state
        s4 = steps4; f4 = fwd4; f1 = fwd1; r1 = rev1;
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < 4; i++) applyStimulus(fwd_seq[i], 5);
        applyStimulus(2'b00, 10);
        checkOutput("x1_fwd_count", fwd1 - f1,   8);
        checkOutput("x1_fwd_norev", rev1 - r1,   0);
        checkOutput("x4_fwd_count", fwd4 - f4,   32);
        checkOutput("x4_fwd_total", steps4 - s4, 32);
        r4 = rev4; f1 = fwd1; r1 = rev1;
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < 4; i++) applyStimulus(rev_seq[i], 5);
        applyStimulus(2'b00, 10);
        checkOutput("x1_rev_count", rev1 - r1, 8);
        checkOutput("x1_rev_nofwd", fwd1 - f1, 0);
        checkOutput("x4_rev_count", rev4 - r4, 32);
        checkOutput("x1_rev_dir",   bus1.dir,  0);

        // Test 4: 2-cycle glitch on A is filtered away
        s4 = steps4; e4 = errs4; s1 = steps1;
        applyStimulus(2'b10, 2);
        applyStimulus(2'b00, 12);
        checkOutput("glitch_ab",    bus4.ab,     2'b00);
        checkOutput("glitch_steps", steps4 - s4, 0);
        checkOutput("glitch_x1",    steps1 - s1, 0);
        checkOutput("glitch_errs",  errs4 - e4,  0);
        checkOutput("glitch_dir",   bus4.dir,    0);

        // Test 5: both pins change at once -> single err, dir held
        s4 = steps4; e4 = errs4; e1 = errs1;
        applyStimulus(2'b11, 12);
        checkOutput("illegal_err4",  errs4 - e4,  1);
        checkOutput("illegal_err1",  errs1 - e1,  1);
        checkOutput("illegal_steps", steps4 - s4, 0);
        checkOutput("illegal_dir",   bus4.dir,    0);
        checkOutput("illegal_ab",    bus4.ab,     2'b11);

        // Test 6: sclr pulse with pins at 01, then resume decoding
        applyStimulus(2'b10, 10);
        applyStimulus(2'b00, 10);
        applyStimulus(2'b01, 10);
        checkOutput("pre_sclr_dir", bus4.dir, 0);
        sclr = 1'b1;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        checkOutput("sclr_step", bus4.step, 0);
        checkOutput("sclr_dir4", bus4.dir,  1);
        checkOutput("sclr_dir1", bus1.dir,  1);
        s4 = steps4; e4 = errs4; s1 = steps1;
        applyStimulus(2'b01, 20);
        checkOutput("resettle_steps4", steps4 - s4, 0);
        checkOutput("resettle_steps1", steps1 - s1, 0);
        checkOutput("resettle_errs",   errs4 - e4,  0);
        checkOutput("resettle_ab",     bus4.ab,     2'b01);
        s4 = steps4; r4 = rev4;
        applyStimulus(2'b11, 10);
        checkOutput("resume_steps", steps4 - s4, 1);
        checkOutput("resume_rev",   rev4 - r4,   1);
        checkOutput("resume_dir",   bus4.dir,    0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
